// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole bus cycle,
// plus a stall watchdog that ends unanswered cycles with an error word.
module wb_master_arbiter #(
   parameter int          TIMEOUT  = 255,
   parameter int          TMO_W    = 8,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_DEAD
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        m0_cyc,
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic [3:0]  m0_sel,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack,
   input  logic        m1_cyc,
   input  logic        m1_stb,
   input  logic        m1_we,
   input  logic [3:0]  m1_sel,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack,
   output logic        s_cyc,
   output logic        s_stb,
   output logic        s_we,
   output logic [3:0]  s_sel,
   output logic [31:0] s_adr,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack,
   output logic [1:0]  grant,
   output logic        timeout_irq,
   output logic [7:0]  timeout_count
);

   typedef enum logic [1:0] {IDLE, BUSY, TERM} state_t;

   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

   state_t           state, state_nxt;
   logic [1:0]       grant_nxt;
   logic             rr_ptr, rr_ptr_nxt;
   logic [TMO_W-1:0] stall_cnt, stall_cnt_nxt, stall_inc;
   logic [7:0]       tmo_cnt_nxt;

   logic             req0, req1;
   logic             own_cyc, own_stb, own_we;
   logic [3:0]       own_sel;
   logic [31:0]      own_adr, own_dat;

   assign req0 = m0_cyc & m0_stb;
   assign req1 = m1_cyc & m1_stb;

   // Owner's signals; only meaningful while grant is non-zero.
   assign own_cyc = grant[1] ? m1_cyc   : m0_cyc;
   assign own_stb = grant[1] ? m1_stb   : m0_stb;
   assign own_we  = grant[1] ? m1_we    : m0_we;
   assign own_sel = grant[1] ? m1_sel   : m0_sel;
   assign own_adr = grant[1] ? m1_adr   : m0_adr;
   assign own_dat = grant[1] ? m1_dat_i : m0_dat_i;

   assign stall_inc = stall_cnt + 1'b1;

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state         <= IDLE;
         grant         <= 2'b00;
         rr_ptr        <= 1'b0;
         stall_cnt     <= '0;
         timeout_count <= 8'd0;
      end else begin
         state         <= state_nxt;
         grant         <= grant_nxt;
         rr_ptr        <= rr_ptr_nxt;
         stall_cnt     <= stall_cnt_nxt;
         timeout_count <= tmo_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      rr_ptr_nxt    = rr_ptr;
      stall_cnt_nxt = stall_cnt;
      tmo_cnt_nxt   = timeout_count;
      s_cyc         = 1'b0;
      s_stb         = 1'b0;
      s_we          = 1'b0;
      s_sel         = 4'd0;
      s_adr         = 32'd0;
      s_dat_o       = 32'd0;
      m0_ack        = 1'b0;
      m1_ack        = 1'b0;
      m0_dat_o      = 32'd0;
      m1_dat_o      = 32'd0;
      timeout_irq   = 1'b0;

      case (state)
         IDLE: begin
            stall_cnt_nxt = '0;
            if (req0 || req1) begin
               grant_nxt = (req1 && (!req0 || rr_ptr)) ? 2'b10 : 2'b01;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            s_cyc    = own_cyc;
            s_stb    = own_stb;
            s_we     = own_we;
            s_sel    = own_sel;
            s_adr    = own_adr;
            s_dat_o  = own_dat;
            m0_ack   = grant[0] & s_ack;
            m1_ack   = grant[1] & s_ack;
            m0_dat_o = grant[0] ? s_dat_i : 32'd0;
            m1_dat_o = grant[1] ? s_dat_i : 32'd0;
            if (!own_cyc) begin
               state_nxt     = IDLE;
               grant_nxt     = 2'b00;
               rr_ptr_nxt    = ~grant[1];
               stall_cnt_nxt = '0;
            end else if (s_ack || !own_stb) begin
               stall_cnt_nxt = '0;
            end else begin
               // An ack in the same cycle takes precedence over the timeout.
               stall_cnt_nxt = stall_inc;
               if (stall_inc == TMO_LIM)
                  state_nxt = TERM;
            end
         end
         TERM: begin
            m0_ack        = grant[0];
            m1_ack        = grant[1];
            m0_dat_o      = grant[0] ? ERR_DATA : 32'd0;
            m1_dat_o      = grant[1] ? ERR_DATA : 32'd0;
            timeout_irq   = 1'b1;
            stall_cnt_nxt = '0;
            if (timeout_count != 8'hFF)
               tmo_cnt_nxt = timeout_count + 8'd1;
            if (own_cyc) begin
               state_nxt = BUSY;
            end else begin
               state_nxt  = IDLE;
               grant_nxt  = 2'b00;
               rr_ptr_nxt = ~grant[1];
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = 2'b00;
         end
      endcase

      // Reset drops any in-flight transfer, including an ack arriving now.
      if (wb_rst) begin
         s_cyc       = 1'b0;
         s_stb       = 1'b0;
         s_we        = 1'b0;
         s_sel       = 4'd0;
         s_adr       = 32'd0;
         s_dat_o     = 32'd0;
         m0_ack      = 1'b0;
         m1_ack      = 1'b0;
         m0_dat_o    = 32'd0;
         m1_dat_o    = 32'd0;
         timeout_irq = 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: arbitration order, hold/release,
// timeout termination, mid-cycle reset and timeout counter saturation.
module tb_wb_master_arbiter;

   logic        wb_clk, wb_rst;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [3:0]  m0_sel, m1_sel, s_sel;
   logic [31:0] m0_adr, m0_dat_i, m0_dat_o, m1_adr, m1_dat_i, m1_dat_o;
   logic        m0_ack, m1_ack;
   logic        s_cyc, s_stb, s_we, s_ack;
   logic [31:0] s_adr, s_dat_o, s_dat_i;
   logic [1:0]  grant;
   logic        timeout_irq;
   logic [7:0]  timeout_count;

   int checks = 0;
   int failures = 0;
   int irq_seen = 0;
   int base;

   wb_master_arbiter dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
      .m0_adr(m0_adr), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
      .m1_adr(m1_adr), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
      .s_adr(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack),
      .grant(grant), .timeout_irq(timeout_irq), .timeout_count(timeout_count)
   );

   initial wb_clk = 1'b0;
   always #5 wb_clk = ~wb_clk;

   always @(negedge wb_clk) if (timeout_irq) irq_seen++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge wb_clk);
      #1;
   endtask

   initial begin
      wb_rst = 1'b1;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF; m0_adr = 0; m0_dat_i = 0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hF; m1_adr = 0; m1_dat_i = 0;
      s_ack = 0; s_dat_i = 0;
      step(); step();
      @(negedge wb_clk);
      chk("rst_grant", grant, 0);
      chk("rst_scyc", s_cyc, 0);
      chk("rst_irq", timeout_irq, 0);
      chk("rst_tcount", timeout_count, 0);
      chk("rst_m0ack", m0_ack, 0);
      step(); wb_rst = 1'b0;

      // Master 0 read alone, slave answers two cycles after strobe.
      m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h3000_0004;
      @(negedge wb_clk);
      chk("rd_idle_grant", grant, 0);
      chk("rd_idle_stb", s_stb, 0);
      step(); @(negedge wb_clk);
      chk("rd_grant", grant, 2'b01);
      chk("rd_sstb", s_stb, 1);
      chk("rd_sadr", s_adr, 32'h3000_0004);
      step(); @(negedge wb_clk);
      chk("rd_noack", m0_ack, 0);
      step(); s_ack = 1; s_dat_i = 32'h1234_5678;
      @(negedge wb_clk);
      chk("rd_ack", m0_ack, 1);
      chk("rd_dat", m0_dat_o, 32'h1234_5678);
      chk("rd_m1ack", m1_ack, 0);
      chk("rd_m1dat", m1_dat_o, 0);
      step(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
      @(negedge wb_clk);
      chk("rd_rel_scyc", s_cyc, 0);
      step(); @(negedge wb_clk);
      chk("rd_rel_grant", grant, 0);

      // Both masters request out of reset; alternation over two rounds.
      step(); wb_rst = 1; step(); wb_rst = 0;
      for (int r = 0; r < 2; r++) begin
         m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
         m0_adr = 32'h3000_0000; m1_adr = 32'h3001_0000;
         @(negedge wb_clk);
         chk("rr_idle_a", grant, 0);
         step(); s_ack = 1; s_dat_i = 32'hA0 + r;
         @(negedge wb_clk);
         chk("rr_g01", grant, 2'b01);
         chk("rr_m0ack", m0_ack, 1);
         chk("rr_m1noack", m1_ack, 0);
         chk("rr_m0dat", m0_dat_o, 32'hA0 + r);
         step(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
         step(); @(negedge wb_clk);
         chk("rr_idle_b", grant, 0);
         step(); s_ack = 1; s_dat_i = 32'hB0 + r;
         @(negedge wb_clk);
         chk("rr_g10", grant, 2'b10);
         chk("rr_m1ack", m1_ack, 1);
         chk("rr_m0noack", m0_ack, 0);
         chk("rr_m1dat", m1_dat_o, 32'hB0 + r);
         step(); s_ack = 0; m1_cyc = 0; m1_stb = 0;
         step(); @(negedge wb_clk);
         chk("rr_idle_c", grant, 0);
         step();
      end

      // Master 1 write to an unmapped address: watchdog terminates it.
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h3003_0000; m1_dat_i = 32'h55AA_33CC;
      step(); @(negedge wb_clk);
      chk("to_sstb", s_stb, 1);
      chk("to_swe", s_we, 1);
      chk("to_sdat", s_dat_o, 32'h55AA_33CC);
      repeat (254) step();
      @(negedge wb_clk);
      chk("to_noack_255", m1_ack, 0);
      chk("to_noirq_255", timeout_irq, 0);
      step(); m1_cyc = 0; m1_stb = 0; m1_we = 0;
      @(negedge wb_clk);
      chk("to_ack", m1_ack, 1);
      chk("to_errdat", m1_dat_o, 32'hDEAD_DEAD);
      chk("to_irq", timeout_irq, 1);
      chk("to_term_stb", s_stb, 0);
      chk("to_term_cyc", s_cyc, 0);
      step(); @(negedge wb_clk);
      chk("to_count", timeout_count, 1);
      chk("to_irq_off", timeout_irq, 0);
      chk("to_grant", grant, 0);

      // Master 0 holds cyc over three strobes while master 1 waits.
      m0_cyc = 1; m0_stb = 1; m0_we = 0; m1_cyc = 1; m1_stb = 1; m1_we = 0;
      step();
      for (int k = 0; k < 3; k++) begin
         s_ack = 1; s_dat_i = 32'hC0 + k;
         @(negedge wb_clk);
         chk("hold_grant", grant, 2'b01);
         chk("hold_m0ack", m0_ack, 1);
         chk("hold_m1ack", m1_ack, 0);
         step(); s_ack = 0; m0_stb = 0;
         if (k == 2) m0_cyc = 0;
         @(negedge wb_clk);
         chk("hold_gap", grant, 2'b01);
         step(); m0_stb = (k < 2);
      end
      @(negedge wb_clk);
      chk("hold_rel", grant, 0);
      step(); @(negedge wb_clk);
      chk("hold_m1win", grant, 2'b10);

      // Reset while master 1 owns the bus and the slave is acking.
      step(); wb_rst = 1; s_ack = 1; s_dat_i = 32'h7777_0000;
      @(negedge wb_clk);
      chk("mrst_m1ack", m1_ack, 0);
      step(); wb_rst = 0;
      @(negedge wb_clk);
      chk("mrst_grant", grant, 0);
      chk("mrst_scyc", s_cyc, 0);
      chk("mrst_m1ack2", m1_ack, 0);
      chk("mrst_m0ack", m0_ack, 0);
      chk("mrst_tcount", timeout_count, 0);
      step(); s_ack = 0; m1_cyc = 0; m1_stb = 0;
      step();

      // 256 back-to-back timeouts: counter saturates, irq keeps pulsing.
      base = irq_seen;
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3003_0000;
      for (int i = 0; i < 66000 && (irq_seen - base) < 256; i++) @(posedge wb_clk);
      #1; m0_cyc = 0; m0_stb = 0;
      @(negedge wb_clk);
      chk("sat_irqs", irq_seen - base, 256);
      chk("sat_count", timeout_count, 8'd255);
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master Wishbone arbiter with bus timeout. Shares the single wishbone slave path into the peripheral bus splitter (UART0/UART1/PORTA decode) between master 0 (management SoC, wbs_* pins) and master 1 (secondary master, e.g. LA-driven test master).
- Round-robin grant, held for a whole bus cycle.
- If no slave responds (unmapped address), a watchdog terminates the cycle so neither master hangs.

Parameters:
- TIMEOUT, 255: stall cycles after which the cycle is terminated; 1 <= TIMEOUT <= 2^TMO_W-1.
- TMO_W, 8: width of the stall counter.
- ERR_DATA, 32'hDEAD_DEAD: read data returned on timeout termination.

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous reset, active-high
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 strobes
- m0_sel  in  4  master 0 byte selects
- m0_adr, m0_dat_i  in  32 each  master 0 address / write data
- m0_dat_o  out  32  read data to master 0
- m0_ack  out  1  ack to master 0
- m1_cyc, m1_stb, m1_we, m1_sel, m1_adr, m1_dat_i, m1_dat_o, m1_ack: same as master 0, for master 1
- s_cyc, s_stb, s_we  out  1 each  to bus splitter
- s_sel  out  4
- s_adr, s_dat_o  out  32 each
- s_dat_i  in  32  slave read data
- s_ack  in  1  slave ack
- grant  out  2  one-hot owner (00 = none)
- timeout_irq  out  1  one-cycle pulse per timeout
- timeout_count  out  8  saturating count of timeouts

Behaviour:
- Reset (synchronous, wb_rst=1 at posedge):
  - state=IDLE, grant=00, rr_ptr=0 (master 0 preferred), stall counter=0, timeout_count=0, timeout_irq=0.
  - All s_* outputs 0; m*_ack 0; m*_dat_o 0.
  - Applies mid-cycle too: an in-flight transfer is dropped with no ack to either master.
- Request: master n requests when mN_cyc & mN_stb.
- IDLE:
  - One request: that master wins.
  - Both request: master rr_ptr wins.
  - Winner is registered into grant; state goes to BUSY next cycle. Arbitration latency is 1 cycle.
  - s_cyc/s_stb are 0 while in IDLE.
- BUSY:
  - Combinationally: s_cyc/s_stb/s_we/s_sel/s_adr/s_dat_o = owner's signals.
  - Owner's ack = s_ack; owner's dat_o = s_dat_i. No added latency.
  - Non-owner: ack=0, dat_o=0. Its signals never reach the slave.
- Grant release:
  - Grant is held while owner cyc=1, so back-to-back strobes in one cycle stay atomic.
  - Owner cyc=0 at a clock edge: state becomes IDLE, grant becomes 00, rr_ptr points to the other master. Costs one idle cycle before the next grant.
- Stall counter:
  - Increments each BUSY cycle with owner stb=1 and s_ack=0.
  - Cleared on s_ack, on entering BUSY, and when owner stb=0.
- Timeout:
  - When the counter equals TIMEOUT, next state is TERM (1 cycle).
  - In TERM: s_cyc=s_stb=0; owner ack=1, owner dat_o=ERR_DATA; timeout_irq=1; timeout_count += 1 (saturates at 255); counter cleared.
  - TERM -> BUSY if owner cyc still 1, else -> IDLE with the same release rules as above.
- Simultaneous events:
  - s_ack in the same cycle the counter reaches TIMEOUT: the ack wins, no timeout.
  - Owner drops cyc in TERM: the ack is still presented for that cycle, then IDLE.
- Late acks: s_ack while not in BUSY is ignored and never forwarded.
- Request changes: a new request from the non-owner during BUSY waits. It is granted on the cycle after release because of rr_ptr.

Test Plan:
- Master 0 read alone, adr 32'h3000_0004, slave acks 2 cycles after s_stb with 32'h1234_5678 -> grant=01 one cycle after request; m0_ack=1 with m0_dat_o=32'h1234_5678 in the s_ack cycle; m1_ack stays 0.
- Both masters request at the same cycle out of reset, each dropping cyc after one ack:
  - -> grant sequence 01, 00, 10, 00.
  - Repeat with both still requesting -> master 0 then master 1 again (alternation).
- Master 1 write to 32'h3003_0000 (unmapped, s_ack never rises), TIMEOUT=255:
  - -> m1_ack=1 with m1_dat_o=32'hDEAD_DEAD exactly 255 stall cycles after s_stb first high, plus the TERM cycle.
  - timeout_irq pulses once; timeout_count=1; s_stb=0 during TERM.
- Master 0 holds cyc across 3 strobes while master 1 requests -> grant stays 01 for all 3 acks; master 1 is granted the cycle after m0_cyc falls.
- wb_rst asserted mid-BUSY with the slave ack pending -> next cycle grant=00, s_cyc=0, no m*_ack, timeout_count=0.
- 256 consecutive timeouts -> timeout_count saturates at 255; timeout_irq still pulses on each.
